// File: rtl/lsu.sv
// Load/store unit between EX and MEM: single-outstanding data-bus
// requests, store lane steering, load extension and misalign flags.
module lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic [2:0]    ex_funct3,
    input  logic [AW-1:0] ex_addr,
    input  logic [31:0]   ex_wdata,
    input  logic          ex_flush,
    output logic          dbus_req,
    output logic          dbus_write,
    output logic [AW-1:0] dbus_addr,
    output logic [31:0]   dbus_wdata,
    output logic [3:0]    dbus_byte_en,
    input  logic          dbus_ready,
    input  logic          dbus_rvalid,
    input  logic [31:0]   dbus_rdata,
    output logic [31:0]   lsu_rdata,
    output logic          lsu_stall,
    output logic          lsu_ld_misalign,
    output logic          lsu_st_misalign
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  ld_fmt_q, ld_fmt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ld_mis_q, ld_mis_d;
    logic        st_mis_q, st_mis_d;

    logic        is_ld, is_st, op;
    logic        sz_b, sz_h, sz_w;
    logic        misaligned, can_issue, rsp, ld_accept;
    logic [31:0] rsp_word, rsp_ext;

    assign is_ld = ex_mem_rd & ~ex_flush;
    assign is_st = ex_mem_wr & ~ex_mem_rd & ~ex_flush;
    assign op    = is_ld | is_st;

    // Decode access size; unlisted funct3 codes behave as word
    always_comb begin
        sz_b = 1'b0;
        sz_h = 1'b0;
        sz_w = 1'b0;
        unique case (ex_funct3)
            3'b000, 3'b100: sz_b = 1'b1;
            3'b001, 3'b101: sz_h = 1'b1;
            default:        sz_w = 1'b1;
        endcase
    end

    assign misaligned = (sz_h & ex_addr[0])
                      | (sz_w & (ex_addr[1:0] != 2'b00));

    assign can_issue = (state_q == S_IDLE)
                     | ((state_q == S_WAIT) & dbus_rvalid);
    assign rsp       = (state_q == S_WAIT) & dbus_rvalid;

    // Reset gate keeps the bus quiet while rst_n is low
    assign dbus_req   = rst_n & op & ~misaligned & can_issue;
    assign dbus_write = is_st;
    assign dbus_addr  = {ex_addr[AW-1:2], 2'b00};
    assign ld_accept  = dbus_req & ~dbus_write & dbus_ready;

    // Store lane steering; loads always fetch the whole word
    always_comb begin
        dbus_byte_en = 4'b1111;
        dbus_wdata   = ex_wdata;
        if (is_st) begin
            unique case (1'b1)
                sz_b: begin
                    dbus_byte_en = 4'b0001 << ex_addr[1:0];
                    dbus_wdata   = {4{ex_wdata[7:0]}};
                end
                sz_h: begin
                    dbus_byte_en = ex_addr[1] ? 4'b1100 : 4'b0011;
                    dbus_wdata   = {2{ex_wdata[15:0]}};
                end
                sz_w: begin
                    dbus_byte_en = 4'b1111;
                    dbus_wdata   = ex_wdata;
                end
                default: ;
            endcase
        end
    end

    assign rsp_word = dbus_rdata >> {ld_fmt_q[1:0], 3'b000};

    // Lane select and extension of the returning load word
    always_comb begin
        rsp_ext = dbus_rdata;
        unique case (ld_fmt_q[4:2])
            3'b000:  rsp_ext = {{24{rsp_word[7]}}, rsp_word[7:0]};
            3'b100:  rsp_ext = {24'h0, rsp_word[7:0]};
            3'b001:  rsp_ext = {{16{rsp_word[15]}}, rsp_word[15:0]};
            3'b101:  rsp_ext = {16'h0, rsp_word[15:0]};
            default: rsp_ext = dbus_rdata;
        endcase
    end

    assign lsu_rdata = rsp ? rsp_ext : rdata_q;
    assign lsu_stall = (dbus_req & ~dbus_ready)
                     | ((state_q == S_WAIT) & ~dbus_rvalid);

    assign lsu_ld_misalign = ld_mis_q;
    assign lsu_st_misalign = st_mis_q;

    // Next-state for the outstanding-load tracker and MEM-side flags
    always_comb begin
        state_d  = state_q;
        ld_fmt_d = ld_fmt_q;
        rdata_d  = rdata_q;
        if (rsp) begin
            rdata_d = rsp_ext;
            state_d = S_IDLE;
        end
        if (ld_accept) begin
            ld_fmt_d = {ex_funct3, ex_addr[1:0]};
            state_d  = S_WAIT;
        end
        ld_mis_d = is_ld & misaligned;
        st_mis_d = is_st & misaligned;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ld_fmt_q <= 5'h0;
            rdata_q  <= 32'h0;
            ld_mis_q <= 1'b0;
            st_mis_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_fmt_q <= ld_fmt_d;
            rdata_q  <= rdata_d;
            ld_mis_q <= ld_mis_d;
            st_mis_q <= st_mis_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: per-cycle behavioural model compare plus
// literal expectations from hand-worked vectors.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_flush;
    logic        dbus_req;
    logic        dbus_write;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byte_en;
    logic        dbus_ready;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_ld_misalign;
    logic        lsu_st_misalign;

    int nvec = 0;
    int nerr = 0;

    lsu #(.AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_flush(ex_flush),
        .dbus_req(dbus_req), .dbus_write(dbus_write),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_byte_en(dbus_byte_en), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall),
        .lsu_ld_misalign(lsu_ld_misalign),
        .lsu_st_misalign(lsu_st_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Extended load value from the architectural rules
    function automatic logic [31:0] ext(input logic [2:0] f,
                                        input logic [1:0] off,
                                        input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f)
            3'b000:  return (v & 32'hFF) - (v[7] ? 32'h100 : 32'h0);
            3'b100:  return v & 32'hFF;
            3'b001:  return (v & 32'hFFFF) - (v[15] ? 32'h10000 : 32'h0);
            3'b101:  return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Model state: is a load pending, its format, last delivered data
    logic        m_busy;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic [31:0] m_last;
    logic        m_ldm, m_stm;

    task automatic model_cycle();
        logic ld, st, mis, e_req;
        logic [31:0] e_rd, e_be, e_wd;
        int sz;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 32'h0;
            m_ldm  = 1'b0;
            m_stm  = 1'b0;
        end
        ld = ex_mem_rd && !ex_flush;
        st = ex_mem_wr && !ex_mem_rd && !ex_flush;
        sz = (ex_funct3[1:0] == 2'd0) ? 0 :
             (ex_funct3[1:0] == 2'd1) ? 1 : 2;
        mis = (sz == 1 && ex_addr[0]) ||
              (sz == 2 && ex_addr[1:0] != 2'd0);
        e_req = rst_n && (ld || st) && !mis && (!m_busy || dbus_rvalid);
        e_rd = (m_busy && dbus_rvalid) ?
               ext(m_f3, m_off, dbus_rdata) : m_last;
        e_be = 32'hF;
        e_wd = ex_wdata;
        if (st && sz == 0) begin
            e_be = 32'h1 << ex_addr[1:0];
            e_wd = (ex_wdata & 32'hFF) * 32'h01010101;
        end else if (st && sz == 1) begin
            e_be = ex_addr[1] ? 32'hC : 32'h3;
            e_wd = (ex_wdata & 32'hFFFF) * 32'h00010001;
        end
        chk("req", {31'h0, dbus_req}, {31'h0, e_req});
        chk("addr", dbus_addr, ex_addr & ~32'h3);
        chk("rdata", lsu_rdata, e_rd);
        chk("stall", {31'h0, lsu_stall},
            {31'h0, (e_req && !dbus_ready) || (m_busy && !dbus_rvalid)});
        chk("ld_mis", {31'h0, lsu_ld_misalign}, {31'h0, m_ldm});
        chk("st_mis", {31'h0, lsu_st_misalign}, {31'h0, m_stm});
        if (e_req) begin
            chk("write", {31'h0, dbus_write}, {31'h0, st});
            chk("byte_en", {28'h0, dbus_byte_en}, e_be);
            if (st) chk("wdata", dbus_wdata, e_wd);
        end
        if (rst_n) begin
            if (m_busy && dbus_rvalid) begin
                m_last = e_rd;
                m_busy = 1'b0;
            end
            if (e_req && ld && dbus_ready) begin
                m_busy = 1'b1;
                m_f3   = ex_funct3;
                m_off  = ex_addr[1:0];
            end
            m_ldm = ld && mis;
            m_stm = st && mis;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 32'h0;
        ex_wdata  = 32'h0;
        ex_flush  = 1'b0;
    endtask

    task automatic set_op(input logic rd, input logic wr,
                          input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd);
        ex_mem_rd = rd;
        ex_mem_wr = wr;
        ex_funct3 = f;
        ex_addr   = a;
        ex_wdata  = wd;
        ex_flush  = 1'b0;
    endtask

    task automatic bus(input logic rdy, input logic rv,
                       input logic [31:0] rd);
        dbus_ready  = rdy;
        dbus_rvalid = rv;
        dbus_rdata  = rd;
    endtask

    initial begin
        int nst;
        int nacc;
        m_busy = 1'b0;
        m_f3   = 3'h0;
        m_off  = 2'h0;
        m_last = 32'h0;
        m_ldm  = 1'b0;
        m_stm  = 1'b0;
        rst_n  = 1'b0;
        idle_in();
        ex_mem_rd = 1'b1;
        ex_addr   = 32'h10;
        bus(1'b1, 1'b0, 32'h0);
        fork
            forever begin
                @(negedge clk);
                model_cycle();
            end
            begin
                // reset state with a load on the inputs
                mid();
                chk("rst_req", {31'h0, dbus_req}, 32'h0);
                chk("rst_rdata", lsu_rdata, 32'h0);
                chk("rst_stall", {31'h0, lsu_stall}, 32'h0);
                tick();
                tick();
                rst_n = 1'b1;
                idle_in();

                // LB / LBU at 0x1003
                tick();
                set_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0);
                mid();
                chk("lb_be", {28'h0, dbus_byte_en}, 32'hF);
                tick();
                idle_in();
                bus(1'b1, 1'b1, 32'h80FF_1234);
                mid();
                chk("lb_data", lsu_rdata, 32'hFFFF_FF80);
                tick();
                set_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0);
                bus(1'b1, 1'b0, 32'h0);
                tick();
                idle_in();
                bus(1'b1, 1'b1, 32'h80FF_1234);
                mid();
                chk("lbu_data", lsu_rdata, 32'h0000_0080);
                tick();
                bus(1'b1, 1'b0, 32'h0);
                mid();
                chk("lbu_hold", lsu_rdata, 32'h0000_0080);

                // SH at 0x2002
                tick();
                set_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF);
                mid();
                chk("sh_be", {28'h0, dbus_byte_en}, 32'hC);
                chk("sh_wd", dbus_wdata, 32'hBEEF_BEEF);
                chk("sh_addr", dbus_addr, 32'h2000);
                chk("sh_stall", {31'h0, lsu_stall}, 32'h0);
                tick();
                set_op(1'b0, 1'b1, 3'b000, 32'h2001, 32'h0000_00A5);
                mid();
                chk("sb_be", {28'h0, dbus_byte_en}, 32'h2);

                // LW: ready low 2 cycles, response 3 cycles after accept
                tick();
                nst = 0;
                set_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
                bus(1'b0, 1'b0, 32'h0);
                for (int i = 0; i < 3; i++) begin
                    if (i == 2) dbus_ready = 1'b1;
                    mid();
                    if (lsu_stall) nst++;
                    tick();
                end
                idle_in();
                for (int i = 0; i < 2; i++) begin
                    mid();
                    if (lsu_stall) nst++;
                    tick();
                end
                bus(1'b1, 1'b1, 32'h1234_5678);
                mid();
                if (lsu_stall) nst++;
                chk("lw_data", lsu_rdata, 32'h1234_5678);
                chk("lw_stalls", nst, 4);
                tick();
                bus(1'b1, 1'b0, 32'h0);
                mid();
                chk("lw_hold", lsu_rdata, 32'h1234_5678);

                // misaligned LW / SH at 0x3001
                tick();
                set_op(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0);
                mid();
                chk("mis_req", {31'h0, dbus_req}, 32'h0);
                chk("mis_stall", {31'h0, lsu_stall}, 32'h0);
                tick();
                idle_in();
                mid();
                chk("ldm_pulse", {31'h0, lsu_ld_misalign}, 32'h1);
                tick();
                mid();
                chk("ldm_clear", {31'h0, lsu_ld_misalign}, 32'h0);
                tick();
                set_op(1'b0, 1'b1, 3'b001, 32'h3001, 32'h1111);
                tick();
                idle_in();
                mid();
                chk("stm_pulse", {31'h0, lsu_st_misalign}, 32'h1);
                chk("stm_ld", {31'h0, lsu_ld_misalign}, 32'h0);

                // three back-to-back LH loads
                tick();
                nst = 0;
                nacc = 0;
                set_op(1'b1, 1'b0, 3'b001, 32'h0, 32'h0);
                mid();
                if (dbus_req && dbus_ready) nacc++;
                if (lsu_stall) nst++;
                tick();
                set_op(1'b1, 1'b0, 3'b001, 32'h2, 32'h0);
                bus(1'b1, 1'b1, 32'h1234_8001);
                mid();
                if (dbus_req && dbus_ready) nacc++;
                if (lsu_stall) nst++;
                chk("lh0", lsu_rdata, 32'hFFFF_8001);
                tick();
                set_op(1'b1, 1'b0, 3'b001, 32'h4, 32'h0);
                bus(1'b1, 1'b1, 32'h7FFF_0000);
                mid();
                if (dbus_req && dbus_ready) nacc++;
                if (lsu_stall) nst++;
                chk("lh2", lsu_rdata, 32'h0000_7FFF);
                tick();
                idle_in();
                bus(1'b1, 1'b1, 32'hABCD_9000);
                mid();
                if (lsu_stall) nst++;
                chk("lh4", lsu_rdata, 32'hFFFF_9000);
                chk("lh_accepts", nacc, 3);
                chk("lh_stalls", nst, 0);

                // flush withdraws a stalled request
                tick();
                set_op(1'b1, 1'b0, 3'b010, 32'h60, 32'h0);
                bus(1'b0, 1'b0, 32'h0);
                mid();
                chk("fl_stall0", {31'h0, lsu_stall}, 32'h1);
                tick();
                ex_flush = 1'b1;
                mid();
                chk("fl_req", {31'h0, dbus_req}, 32'h0);
                chk("fl_stall1", {31'h0, lsu_stall}, 32'h0);

                // reset in WAIT, then stray response
                tick();
                set_op(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
                bus(1'b1, 1'b0, 32'h0);
                tick();
                idle_in();
                mid();
                chk("wait_stall", {31'h0, lsu_stall}, 32'h1);
                tick();
                rst_n = 1'b0;
                mid();
                chk("rw_rdata", lsu_rdata, 32'h0);
                chk("rw_stall", {31'h0, lsu_stall}, 32'h0);
                tick();
                rst_n = 1'b1;
                tick();
                bus(1'b1, 1'b1, 32'hDEAD_BEEF);
                mid();
                chk("stray_rdata", lsu_rdata, 32'h0);
                chk("stray_stall", {31'h0, lsu_stall}, 32'h0);
                tick();
                bus(1'b1, 1'b0, 32'h0);
                mid();
                chk("stray_hold", lsu_rdata, 32'h0);
                tick();
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between EX and MEM. Takes the memory op and address computed in EX, drives a single-outstanding data-bus request, and returns sign/zero-extended load data as `lsu_rdata`, consumed by MEM in the following cycle. Handles byte-lane steering for stores, misalignment detection, and stalls the pipeline while the bus is busy or a load response is pending.

## Interface
- `AW`, 32, data-bus byte-address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_mem_rd`  in  1  EX instruction is a load.
- `ex_mem_wr`  in  1  EX instruction is a store.
- `ex_funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
- `ex_addr`  in  AW  byte address from ALU.
- `ex_wdata`  in  32  store data, unaligned in bits [7:0]/[15:0]/[31:0].
- `ex_flush`  in  1  kill the EX op; no request is issued.
- `dbus_req`  out  1  request valid.
- `dbus_write`  out  1  1 = store.
- `dbus_addr`  out  AW  word-aligned address, `{ex_addr[AW-1:2],2'b00}`.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_byte_en`  out  4  byte enables.
- `dbus_ready`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  load response valid.
- `dbus_rdata`  in  32  load response word.
- `lsu_rdata`  out  32  extended load data for MEM.
- `lsu_stall`  out  1  freeze the IF–EX/MEM pipeline registers.
- `lsu_ld_misalign`  out  1  registered misaligned-load flag, aligned with the op in MEM.
- `lsu_st_misalign`  out  1  registered misaligned-store flag, aligned with the op in MEM.

## Operation
- FSM states:
  - IDLE: no load outstanding.
  - WAIT: one load accepted, response pending.
- `op = (ex_mem_rd | ex_mem_wr) & ~ex_flush`.
- Misaligned: H/HU with `addr[0]=1`; W with `addr[1:0]!=0`.
- `can_issue = (state==IDLE) | (state==WAIT & dbus_rvalid)`.
- `dbus_req = op & ~misaligned & can_issue`. All `dbus_*` outputs are combinational from EX inputs.
- Store steering by size:
  - SB: `byte_en = 1<<addr[1:0]`, wdata = byte ×4.
  - SH: `byte_en = addr[1]` ? 1100 : 0011, wdata = halfword ×2.
  - SW: `byte_en = 1111`.
  - Loads drive `byte_en = 1111`.
- Load accepted (`req & ~write & ready`): capture `funct3` and `addr[1:0]` into `ld_fmt_q`; next state WAIT.
- Accepted store: posted write, no response expected; state is unchanged unless a load response completes in the same cycle.
- In WAIT with `rvalid`: select the lane by `ld_fmt_q` offset and extend (B/H sign-extend, BU/HU zero-extend, W passthrough).
  - `lsu_rdata` = extended value combinationally in the same cycle; it is also registered into `rdata_q`.
  - Next state: WAIT if a new load is accepted the same cycle, else IDLE.
- Outside a response cycle, `lsu_rdata = rdata_q`.
- `lsu_stall = (dbus_req & ~dbus_ready) | (state==WAIT & ~dbus_rvalid)`.
- Misaligned op: no bus request and no stall. The flag is registered next cycle (`ld` for a load, `st` for a store); otherwise the flag registers 0.
- `rvalid` in IDLE (stale response) is ignored and `rdata_q` is unchanged.
- `ex_mem_rd` and `ex_mem_wr` both high is illegal; the load takes priority.

## Timing
- Reset values:
  - state IDLE
  - `rdata_q = 0`
  - `ld_fmt_q = 0`
  - `lsu_ld_misalign = 0`, `lsu_st_misalign = 0`
  - `dbus_req = 0` while `rst_n = 0`, whatever the inputs
- Zero-wait bus: request in cycle N, `rvalid` in N+1, `lsu_rdata` valid in N+1 combinationally for MEM. No stall.
- Each cycle `dbus_ready` is low adds one stall cycle; the request is held stable while `lsu_stall` is high.
- Each cycle response latency exceeds 1 adds one stall cycle in WAIT.
- Back-to-back loads sustain one per cycle on a zero-wait bus.
- `ex_flush` while `dbus_req` is stalled withdraws the request in that cycle.
- `ex_flush` never cancels a load already accepted; WAIT still completes.
- Reset mid-WAIT: immediate return to IDLE; a later `rvalid` is ignored.
- Misalign flags are valid exactly one cycle after the EX op, then clear unless repeated.

## Test plan
- LB at addr 0x1003, `rdata` 0x80FF_1234 -> `byte_en` 1111, `lsu_rdata` 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x2002, wdata 0x0000_BEEF -> `byte_en` 1100, `dbus_wdata` 0xBEEF_BEEF, `dbus_addr` 0x2000, no stall.
- LW with `dbus_ready` low for 2 cycles, then `rvalid` 3 cycles after accept -> `lsu_stall` high for 4 cycles total; `lsu_rdata` equals `rdata` on the response cycle and holds afterwards.
- LW at 0x3001 -> no `dbus_req`, `lsu_ld_misalign` = 1 for exactly one cycle. SH at 0x3001 -> `lsu_st_misalign` pulse.
- Three back-to-back LH loads (0x0, 0x2, 0x4) on a zero-wait bus -> three accepts in consecutive cycles, zero stall cycles, correct sign-extended halves.
- Assert `rst_n` low in WAIT, release, then drive a stray `rvalid` with 0xDEAD_BEEF -> state IDLE, `lsu_rdata` stays 0, `lsu_stall` stays 0.
